adder_arbiter: RTL and testbench



---
 rtl/adder_arb_pkg.sv | 26 ++
 rtl/adder_arbiter_rr_pick.sv | 42 ++++
 rtl/adder_arbiter.sv | 116 +++++++++++
 tb/tb_adder_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// ============================================================================
// adder_arb_pkg : shared types and defaults for the adder arbiter
// Revision      : 1.0
// ============================================================================
`default_nettype none

package adder_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_N_REQ  = 3;

    typedef logic [DEF_DATA_W-1:0] data_t;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rsp_state_e;

    // Signed overflow: like-signed operands producing an opposite-signed sum.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_arbiter_rr_pick.sv
// ============================================================================
// rr_pick  : combinational round-robin picker, search starts at ptr and wraps
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N_REQ = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [ID_W-1:0]  idx_o,
    output logic             any_valid_o
);

    always_comb begin
        int          j;
        logic [ID_W-1:0] sel;
        grant_o     = '0;
        idx_o       = '0;
        any_valid_o = 1'b0;
        j           = 0;
        sel         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            sel = ID_W'(j);
            if (!any_valid_o && req_i[sel]) begin
                any_valid_o  = 1'b1;
                idx_o        = sel;
                grant_o[sel] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/adder_arbiter.sv
// ============================================================================
// adder_arbiter : round-robin shared adder with one-entry tagged output register
//                 ADDER_ARB_FLAGS_EN enables registered carry/overflow flags
// Revision      : 1.0
// ============================================================================
`default_nettype none

module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ID_W   = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [DATA_W-1:0]       rsp_sum,
    output logic                    rsp_cout,
    output logic                    rsp_ovf
);

    localparam logic [ID_W-1:0] C_LAST_IDX = ID_W'(N_REQ - 1);

    rsp_state_e        state_q;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   ptr_d;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] sum_q;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_win_idx;
    logic              w_any_valid;
    logic              w_can_accept;
    logic              w_xfer;
    logic [DATA_W-1:0] w_op_a;
    logic [DATA_W-1:0] w_op_b;
    logic [DATA_W-1:0] w_sum;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i       (req_valid),
        .ptr_i       (ptr_q),
        .grant_o     (w_grant),
        .idx_o       (w_win_idx),
        .any_valid_o (w_any_valid)
    );

    assign w_can_accept = (state_q == EMPTY) || rsp_ready;
    // Gating with rst_n keeps every grant low while reset is held.
    assign w_xfer       = rst_n && w_can_accept && w_any_valid;
    assign req_ready    = w_xfer ? w_grant : '0;

    assign w_op_a = req_a[int'(w_win_idx)*DATA_W +: DATA_W];
    assign w_op_b = req_b[int'(w_win_idx)*DATA_W +: DATA_W];

    assign ptr_d  = (w_win_idx == C_LAST_IDX) ? '0 : w_win_idx + ID_W'(1);

`ifdef ADDER_ARB_FLAGS_EN
    logic [DATA_W:0] w_sum_ext;
    logic            cout_q;
    logic            ovf_q;

    assign w_sum_ext = {1'b0, w_op_a} + {1'b0, w_op_b};
    assign w_sum     = w_sum_ext[DATA_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (w_xfer) begin
            cout_q <= w_sum_ext[DATA_W];
            ovf_q  <= add_ovf(w_op_a[DATA_W-1], w_op_b[DATA_W-1], w_sum_ext[DATA_W-1]);
        end
    end

    assign rsp_cout = cout_q;
    assign rsp_ovf  = ovf_q;
`else
    assign w_sum    = w_op_a + w_op_b;
    assign rsp_cout = 1'b0;
    assign rsp_ovf  = 1'b0;
`endif

    // A grant on a draining edge reloads the register, so no bubble appears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
        end else if (w_xfer) begin
            state_q <= FULL;
            ptr_q   <= ptr_d;
            id_q    <= w_win_idx;
            sum_q   <= w_sum;
        end else if ((state_q == FULL) && rsp_ready) begin
            state_q <= EMPTY;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_q;
    assign rsp_sum   = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_adder_arbiter.sv
// ============================================================================
// tb_adder_arbiter : vector table, corner sequences and randomized model check
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_adder_arbiter;

    localparam int N  = 3;
    localparam int W  = 32;
    localparam int IW = 2;
`ifdef ADDER_ARB_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           rsp_ovf;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    adder_arbiter #(.N_REQ(N), .DATA_W(W), .ID_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    typedef struct packed {
        logic [N-1:0]   valid;
        logic [N*W-1:0] a;
        logic [N*W-1:0] b;
        logic           rdy;
        logic [N-1:0]   exp_ready;
        logic           exp_valid;
        logic [IW-1:0]  exp_id;
        logic [W-1:0]   exp_sum;
        logic           exp_cout;
        logic           exp_ovf;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick_val();
        case ($urandom_range(0, 5))
            0:       return 32'hFFFF_FFFF;
            1:       return 32'h7FFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // Reference model state
    int           m_ptr;
    bit           m_full;
    int           m_id;
    logic [W-1:0] m_sum;
    bit           m_cout;
    bit           m_ovf;
    bit           pend[N];
    logic [W-1:0] ra[N];
    logic [W-1:0] rb[N];

    initial begin
        logic [N-1:0] exp_rdy;
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        tbl[0]  = '{3'b010, {32'd0, 32'd4, 32'd0}, {32'd0, 32'h0040_0000, 32'd0}, 1'b1, 3'b010, 1'b1, 2'd1, 32'h0040_0004, 1'b0, 1'b0};
        tbl[1]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1, 3'b100, 1'b1, 2'd2, 32'd33, 1'b0, 1'b0};
        tbl[2]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1, 3'b001, 1'b1, 2'd0, 32'd11, 1'b0, 1'b0};
        tbl[3]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b1, 3'b010, 1'b1, 2'd1, 32'd22, 1'b0, 1'b0};
        tbl[4]  = '{3'b111, {32'd30, 32'd20, 32'd10}, {32'd3, 32'd2, 32'd1}, 1'b0, 3'b000, 1'b1, 2'd1, 32'd22, 1'b0, 1'b0};
        tbl[5]  = '{3'b000, {32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0}, 1'b1, 3'b000, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0};
        tbl[6]  = '{3'b001, {32'd0, 32'd0, 32'd11}, {32'd0, 32'd0, 32'd0}, 1'b0, 3'b001, 1'b1, 2'd0, 32'd11, 1'b0, 1'b0};
        tbl[7]  = '{3'b101, {32'd100, 32'd0, 32'd1}, {32'd5, 32'd0, 32'd0}, 1'b1, 3'b100, 1'b1, 2'd2, 32'd105, 1'b0, 1'b0};
        tbl[8]  = '{3'b001, {32'd0, 32'd0, 32'hFFFF_FFFF}, {32'd0, 32'd0, 32'd1}, 1'b1, 3'b001, 1'b1, 2'd0, 32'd0, 1'b1, 1'b0};
        tbl[9]  = '{3'b010, {32'd0, 32'h7FFF_FFFF, 32'd0}, {32'd0, 32'd1, 32'd0}, 1'b1, 3'b010, 1'b1, 2'd1, 32'h8000_0000, 1'b0, 1'b1};
        tbl[10] = '{3'b000, {32'd0, 32'd0, 32'd0}, {32'd0, 32'd0, 32'd0}, 1'b0, 3'b000, 1'b1, 2'd1, 32'h8000_0000, 1'b0, 1'b1};

        // Reset values, with requests present to show grants are held off
        #2;
        req_valid = 3'b111;
        #1;
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_valid", 64'(rsp_valid), 64'd0);
        chk("rst_sum",   64'(rsp_sum),   64'd0);
        chk("rst_id",    64'(rsp_id),    64'd0);
        chk("rst_cout",  64'(rsp_cout),  64'd0);
        chk("rst_ovf",   64'(rsp_ovf),   64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            req_valid = tbl[i].valid;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            rsp_ready = tbl[i].rdy;
            #4;
            chk($sformatf("tbl%0d_ready", i), 64'(req_ready), 64'(tbl[i].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_valid", i), 64'(rsp_valid), 64'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                chk($sformatf("tbl%0d_id", i),   64'(rsp_id),   64'(tbl[i].exp_id));
                chk($sformatf("tbl%0d_sum", i),  64'(rsp_sum),  64'(tbl[i].exp_sum));
                chk($sformatf("tbl%0d_cout", i), 64'(rsp_cout), FLAGS ? 64'(tbl[i].exp_cout) : 64'd0);
                chk($sformatf("tbl%0d_ovf", i),  64'(rsp_ovf),  FLAGS ? 64'(tbl[i].exp_ovf)  : 64'd0);
            end
        end

        // Back-pressure: FULL (id 1, sum 0x8000_0000), ptr = 2
        req_valid = 3'b111;
        req_a     = {32'd7, 32'd6, 32'd5};
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (4) begin
            #4;
            chk("bp_ready", 64'(req_ready), 64'd0);
            @(posedge clk); #1;
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_id",    64'(rsp_id),    64'd1);
            chk("bp_sum",   64'(rsp_sum),   64'h8000_0000);
        end
        rsp_ready = 1'b1;
        #4;
        chk("bp_release_ready", 64'(req_ready), 64'b100);
        @(posedge clk); #1;
        chk("bp_reload_valid", 64'(rsp_valid), 64'd1);
        chk("bp_reload_id",    64'(rsp_id),    64'd2);
        chk("bp_reload_sum",   64'(rsp_sum),   64'd7);

        // Reset mid-operation while FULL with ptr = 2
        req_valid = 3'b010;
        @(posedge clk); #1;
        chk("pre_rst_id", 64'(rsp_id), 64'd1);
        rsp_ready = 1'b0;
        req_valid = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rsp_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        #1;
        rst_n = 1'b1;
        #2;
        chk("post_rst_ready", 64'(req_ready), 64'b001);
        @(posedge clk); #1;
        chk("post_rst_id",  64'(rsp_id),  64'd0);
        chk("post_rst_sum", 64'(rsp_sum), 64'd5);

        // Randomized run against the reference model
        req_valid = '0;
        rst_n     = 1'b0;
        #3;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        m_ptr = 0; m_full = 0; m_id = 0; m_sum = '0; m_cout = 0; m_ovf = 0;
        for (int r = 0; r < N; r++) begin
            pend[r] = 0; ra[r] = '0; rb[r] = '0;
        end

        for (int cyc = 0; cyc < 400; cyc++) begin
            bit can;
            int win;
            for (int r = 0; r < N; r++) begin
                if (!pend[r] && $urandom_range(0, 2) == 0) begin
                    pend[r] = 1;
                    ra[r]   = pick_val();
                    rb[r]   = pick_val();
                end
                req_valid[r]       = pend[r];
                req_a[r*W +: W]    = ra[r];
                req_b[r*W +: W]    = rb[r];
            end
            rsp_ready = ($urandom_range(0, 3) != 0);

            can = !m_full || rsp_ready;
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (win < 0 && pend[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            end
            exp_rdy = (can && win >= 0) ? N'(1 << win) : '0;
            #4;
            chk("rnd_ready", 64'(req_ready), 64'(exp_rdy));
            @(posedge clk);
            if (can && win >= 0) begin
                logic [W:0] s;
                longint     ss;
                s      = {1'b0, ra[win]} + {1'b0, rb[win]};
                ss     = longint'($signed(ra[win])) + longint'($signed(rb[win]));
                m_full = 1;
                m_id   = win;
                m_sum  = s[W-1:0];
                m_cout = FLAGS && s[W];
                m_ovf  = FLAGS && (ss > 64'sd2147483647 || ss < -64'sd2147483648);
                m_ptr  = (win + 1) % N;
                pend[win] = 0;
            end else if (m_full && rsp_ready) begin
                m_full = 0;
            end
            #1;
            chk("rnd_valid", 64'(rsp_valid), 64'(m_full));
            if (m_full) begin
                chk("rnd_id",   64'(rsp_id),   64'(m_id));
                chk("rnd_sum",  64'(rsp_sum),  64'(m_sum));
                chk("rnd_cout", 64'(rsp_cout), 64'(m_cout));
                chk("rnd_ovf",  64'(rsp_ovf),  64'(m_ovf));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
